// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per clock, with a start/busy/done handshake toward register write-back.
module mul_div_unit #(
    parameter int reg_addr_width = 5,
    parameter int reg_data_width = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [2:0]                funct3,
    input  logic [reg_data_width-1:0] op_a,
    input  logic [reg_data_width-1:0] op_b,
    input  logic [reg_addr_width-1:0] rd_in,
    output logic                      busy,
    output logic                      done,
    output logic [reg_data_width-1:0] result,
    output logic [reg_addr_width-1:0] rd_out
);

    localparam int W  = reg_data_width;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e                    state_q, state_d;
    logic [2:0]                op_q, op_d;
    logic [reg_addr_width-1:0] rd_q, rd_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [W-1:0]              opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic [2*W-1:0]            acc_q, acc_d;     // product, or quotient in the low half
    logic [W-1:0]              rem_q, rem_d;
    logic                      neg_q, neg_d;
    logic                      rem_neg_q, rem_neg_d;
    logic [W-1:0]              result_q, result_d;

    logic         is_div, signed_a, signed_b, sign_a, sign_b;
    logic         div_zero, div_ovf;
    logic [W-1:0] mag_a, mag_b;

    // Operand decode at the start edge: signedness, magnitudes and special cases.
    always_comb begin
        is_div   = funct3[2];
        signed_a = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        signed_b = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        sign_a   = signed_a & op_a[W-1];
        sign_b   = signed_b & op_b[W-1];
        mag_a    = sign_a ? -op_a : op_a;
        mag_b    = sign_b ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    end

    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next, prod_fixed;
    logic [W:0]     div_shift, div_trial;
    logic           div_fits;
    logic [W-1:0]   rem_next, div_quo, quo_fixed, rem_fixed;

    // One iteration of each datapath, plus the sign-corrected final values.
    always_comb begin
        mul_sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next   = {mul_sum, acc_q[W-1:1]};
        div_shift  = {rem_q, acc_q[W-1]};
        div_trial  = div_shift - {1'b0, opnd_q};
        div_fits   = ~div_trial[W];
        rem_next   = div_fits ? div_trial[W-1:0] : div_shift[W-1:0];
        div_quo    = {acc_q[W-2:0], div_fits};
        prod_fixed = neg_q ? -mul_next : mul_next;
        quo_fixed  = neg_q ? -div_quo : div_quo;
        rem_fixed  = rem_neg_q ? -rem_next : rem_next;
    end

    always_comb begin
        // NOTE: every target gets a hold-value default first so no path infers a latch.
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = funct3;
                    rd_d      = rd_in;
                    cnt_d     = CW'(W - 1);
                    neg_d     = sign_a ^ sign_b;
                    rem_neg_d = sign_a;
                    opnd_d    = is_div ? mag_b : mag_a;
                    acc_d     = {{W{1'b0}}, (is_div ? mag_a : mag_b)};
                    rem_d     = '0;
                    if (div_zero) begin
                        result_d = funct3[1] ? op_a : '1;
                        state_d  = DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : MIN_NEG;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q[2]) begin
                    acc_d = {acc_q[2*W-1:W], div_quo};
                    rem_d = rem_next;
                end else begin
                    acc_d = mul_next;
                end
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (op_q[2])
                        result_d = op_q[1] ? rem_fixed : quo_fixed;
                    else
                        result_d = (op_q[1:0] == 2'b00) ? prod_fixed[W-1:0] : prod_fixed[2*W-1:W];
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected results, a monitor
// pops them on every done pulse; timing and reset behaviour are checked inline.
module tb_mul_div_unit;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic        clk, rst_n, start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   passed;

    mul_div_unit #(.reg_addr_width(5), .reg_data_width(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct3(funct3),
        .op_a  (op_a),
        .op_b  (op_b),
        .rd_in (rd_in),
        .busy  (busy),
        .done  (done),
        .result(result),
        .rd_out(rd_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference semantics from the RV32M rules using wide integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            F_MUL:    p = ua * ub;
            F_MULH:   p = (sa * sb) >>> 32;
            F_MULHSU: p = (sa * ub) >>> 32;
            F_MULHU:  p = (ua * ub) >> 32;
            F_DIV: begin
                if (b == 0) p = -1;
                else if (a == MIN_NEG && b == 32'hFFFF_FFFF) p = {32'b0, MIN_NEG};
                else p = sa / sb;
            end
            F_DIVU: p = (b == 0) ? -1 : ua / ub;
            F_REM: begin
                if (b == 0) p = ua;
                else if (a == MIN_NEG && b == 32'hFFFF_FFFF) p = 0;
                else p = sa % sb;
            end
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF));
    endfunction

    // Called at posedge+1 with the DUT idle; returns in cycle 1 of the operation.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        exp_t e;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        e.res  = ref_model(f, a, b);
        e.rd   = rd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        rd_in  = 5'($urandom);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        int lat;
        lat = 0;
        issue(f, a, b, rd);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
        end
        check("done_seen", done, 1'b1);
        check("latency", lat, is_special(f, a, b) ? 32'd1 : 32'd33);
        @(posedge clk);
        #1;
        check("idle_after_done", busy, 1'b0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", done, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
                end
            end
        end
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_rd_out", {27'b0, rd_out}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cycle-by-cycle handshake of a normal operation.
        issue(F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3);
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            check("t_busy", busy, c <= 33);
            check("t_done", done, c == 33);
        end
        @(posedge clk);
        #1;

        run_op(F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1);
        run_op(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op(F_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd3);
        run_op(F_DIV,    32'hFFFF_FFF9, 32'd2,         5'd13);
        run_op(F_REM,    32'hFFFF_FFF9, 32'd2,         5'd13);
        run_op(F_DIVU,   32'hFFFF_FFF9, 32'd2,         5'd13);
        run_op(F_REMU,   32'hFFFF_FFF9, 32'd2,         5'd13);
        run_op(F_DIV,    32'd5,         32'd0,         5'd6);
        run_op(F_REM,    32'd5,         32'd0,         5'd6);
        run_op(F_DIVU,   32'd5,         32'd0,         5'd0);
        run_op(F_REMU,   32'd5,         32'd0,         5'd0);
        run_op(F_DIV,    MIN_NEG,       32'hFFFF_FFFF, 5'd8);
        run_op(F_REM,    MIN_NEG,       32'hFFFF_FFFF, 5'd8);

        // Start pulses while busy (including the DONE cycle) must be ignored.
        issue(F_MUL, 32'd3, 32'd4, 5'd7);
        for (int c = 1; c <= 40; c++) begin
            start  = (c == 5 || c == 33);
            funct3 = F_MUL;
            op_a   = 32'd9;
            op_b   = 32'd9;
            rd_in  = 5'd21;
            @(negedge clk);
            check("ign_busy", busy, c <= 33);
            check("ign_done", done, c == 33);
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        // Asynchronous reset in cycle 10 of a divide aborts it without a done pulse.
        issue(F_DIV, 32'd1000, 32'd3, 5'd9);
        repeat (9) @(posedge clk);
        #2;
        check("pending_before_reset", exp_q.size(), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 32'h0);
        check("abort_rd_out", {27'b0, rd_out}, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(F_DIVU, 32'd100, 32'd7, 5'd4);
        run_op(F_REMU, 32'd100, 32'd7, 5'd4);

        // Randomised operations, biased toward the division corner cases.
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: begin
                    a = MIN_NEG;
                    b = 32'hFFFF_FFFF;
                end
                3: a = $urandom_range(0, 100);
                default: ;
            endcase
            run_op(f, a, b, 5'($urandom));
        end

        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file. It consumes the two source-operand read ports and the destination register index. It computes one M-extension operation with a start/busy/done handshake, then presents the result and destination index for write-back into the register file. Multiplication uses shift-add and division uses restoring, one bit per clock.

## Interface
- reg_addr_width, default 5: destination register index width
- reg_data_width, default 32: operand/result width; the iteration count equals this value
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  request; sampled only in IDLE
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  reg_data_width  rs1 value (register file r_data1)
- op_b  input  reg_data_width  rs2 value (register file r_data2)
- rd_in  input  reg_addr_width  destination index, latched with start
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse; result and rd_out are valid in the same cycle
- result  output  reg_data_width  registered result; held until the next done
- rd_out  output  reg_addr_width  latched destination index (wr_addr for write-back)

## Operation
- States: IDLE, CALC, DONE.
- IDLE, start=1:
  - Latch funct3 and rd_in.
  - Latch operand magnitudes and sign flags.
  - Load iteration counter with reg_data_width-1.
  - Go to CALC, unless a special division case applies (see below); then go to DONE.
- Signedness:
  - Signed on both operands: MULH, DIV, REM.
  - op_a signed, op_b unsigned: MULHSU.
  - Unsigned on both operands: MUL, MULHU, DIVU, REMU. MUL takes its low word from the unsigned product, which is identical for signed operands.
- CALC, multiply:
  - 2*reg_data_width product accumulator.
  - Each cycle, conditionally add the multiplicand and shift by one.
- CALC, divide:
  - Restoring division, one quotient bit per cycle.
  - Partial remainder is reg_data_width+1 bits.
- CALC exit: counter decrements each cycle; when it is 0 the final iteration completes, the state goes to DONE and the result register loads.
- Result select and sign fix on the DONE transition:
  - Product sign is sign_a XOR sign_b, applied to the full 64-bit product.
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
  - Quotient sign is sign_a XOR sign_b.
  - Remainder sign follows the dividend.
- Special division cases, detected in IDLE at start and sent directly to DONE:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give op_a.
  - Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start while busy=1, including the DONE cycle, is ignored and not queued.
- rd_in=0 is passed through unchanged; the register file hardwires x0.

## Timing
- Reset values: state IDLE, busy 0, done 0, result 0, rd_out 0, counter 0.
- Cycle numbering: start high in cycle 0, with rising edge at the end of cycle 0.
- Normal op:
  - busy high in cycles 1–33.
  - CALC occupies cycles 1–32.
  - done=1 and the result is valid in cycle 33.
  - IDLE from cycle 34; a new start is accepted in cycle 34.
- Special div case: busy and done high in cycle 1 only; IDLE in cycle 2.
- Operands are latched at the start edge. op_a, op_b and rd_in may change freely afterwards.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately, asynchronously.
  - No done pulse is produced for the aborted op.
  - Operation resumes from IDLE on the first edge after rst_n rises.
- Back-to-back throughput: one op per 34 cycles (2 cycles for special cases).

## Test plan
- Reset, then MUL op_a=7, op_b=0xFFFFFFFD -> busy cycles 1–33; done only in cycle 33; result 0xFFFFFFEB.
- High-word multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
  - REMU same operands -> 1.
  - rd_in=13 -> rd_out=13 at done.
- Divide by zero, op_a=5:
  - DIV -> 0xFFFFFFFF; REM -> 5.
  - Both give done in cycle 1 and busy low in cycle 2.
- Overflow, op_a=0x80000000, op_b=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0; done in cycle 1.
- Start and reset handling:
  - start pulses in cycles 5 and 33 during a MUL 3×4 -> single done in cycle 33 with result 12.
  - rst_n low in cycle 10 of a DIV -> busy/done/result 0 immediately, with no done.
  - After release, DIVU 100/7 -> 14, and REMU -> 2.
